// File: rtl/gray_seq_checker_if.sv
// Sample/result bundle between the gray stream source and gray_seq_checker.
interface gray_seq_checker_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] gray_in;
  logic             clear_err;
  logic [WIDTH-1:0] bin_out;
  logic             bin_valid;
  logic             step_err;
  logic             hold;
  logic             locked;
  logic             err_sticky;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] wrap_count;

  modport master (
    output in_valid, gray_in, clear_err,
    input  bin_out, bin_valid, step_err, hold, locked,
           err_sticky, err_count, wrap_count
  );

  modport slave (
    input  in_valid, gray_in, clear_err,
    output bin_out, bin_valid, step_err, hold, locked,
           err_sticky, err_count, wrap_count
  );
endinterface

// File: rtl/gray_seq_checker.sv
// Checks a sampled gray code stream for legal +1 steps; tracks lock,
// error and wrap statistics with all results registered.
module gray_seq_checker #(
  parameter int WIDTH     = 4,
  parameter int CNT_W     = 8,
  parameter int ERR_LIMIT = 3,
  parameter int LOCK_GOOD = 2
) (
  input  logic               clk,
  input  logic               rst,
  gray_seq_checker_if.slave  bus
);

  localparam int GW = $clog2(LOCK_GOOD + 1);
  localparam int BW = $clog2(ERR_LIMIT + 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_GOOD - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(ERR_LIMIT - 1);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  state_t           state;
  logic [WIDTH-1:0] prev_gray;
  logic [WIDTH-1:0] prev_bin;
  logic [GW-1:0]    good_cnt;
  logic [BW-1:0]    bad_cnt;

  logic [WIDTH-1:0] bin_in;
  logic             is_hold;
  logic             is_good;

  // Each binary bit is the XOR of all gray bits at or above it.
  always_comb begin
    bin_in = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      bin_in[i] = ^(bus.gray_in >> i);
    end
    is_hold = (bus.gray_in == prev_gray);
    is_good = ($countones(bus.gray_in ^ prev_gray) == 1) &&
              (bin_in == prev_bin + WIDTH'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= UNLOCKED;
      prev_gray      <= '0;
      prev_bin       <= '0;
      good_cnt       <= '0;
      bad_cnt        <= '0;
      bus.bin_out    <= '0;
      bus.bin_valid  <= 1'b0;
      bus.step_err   <= 1'b0;
      bus.hold       <= 1'b0;
      bus.locked     <= 1'b0;
      bus.err_sticky <= 1'b0;
      bus.err_count  <= '0;
      bus.wrap_count <= '0;
    end else begin
      bus.bin_valid <= 1'b0;
      bus.step_err  <= 1'b0;
      bus.hold      <= 1'b0;
      if (bus.clear_err) begin
        bus.err_count  <= '0;
        bus.err_sticky <= 1'b0;
      end
      if (bus.in_valid) begin
        bus.bin_out   <= bin_in;
        bus.bin_valid <= 1'b1;
        prev_gray     <= bus.gray_in;
        prev_bin      <= bin_in;
        case (state)
          UNLOCKED: begin
            state    <= ACQUIRE;
            good_cnt <= '0;
          end
          ACQUIRE: begin
            if (is_good) begin
              if (good_cnt == GOOD_LAST) begin
                state      <= LOCKED;
                bus.locked <= 1'b1;
                good_cnt   <= '0;
              end else begin
                good_cnt <= good_cnt + GW'(1);
              end
            end else if (!is_hold) begin
              good_cnt <= '0;
            end
          end
          LOCKED: begin
            if (is_hold) begin
              bus.hold <= 1'b1;
            end else if (is_good) begin
              bad_cnt <= '0;
              if (&prev_bin) bus.wrap_count <= bus.wrap_count + CNT_W'(1);
            end else begin
              bus.step_err   <= 1'b1;
              bus.err_sticky <= 1'b1;
              // An error in the same cycle as clear_err restarts the count at 1.
              if (bus.clear_err)       bus.err_count <= CNT_W'(1);
              else if (!(&bus.err_count)) bus.err_count <= bus.err_count + CNT_W'(1);
              if (bad_cnt == BAD_LAST) begin
                state      <= UNLOCKED;
                bus.locked <= 1'b0;
                bad_cnt    <= '0;
              end else begin
                bad_cnt <= bad_cnt + BW'(1);
              end
            end
          end
          default: begin
            state      <= UNLOCKED;
            bus.locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/gray_seq_checker.md
Name: gray_seq_checker

Overview:
- Downstream consumer of the gray counter output: samples the gray code stream, converts it to binary and checks every step is a legal single-bit, +1 transition.
- Maintains lock state, error/wrap statistics and a sticky error flag for the verification environment and for on-chip self-check.
- Sits directly after gray_counter; its gray_in is driven by the counter's out.

Parameters:
WIDTH, 4, gray/binary code width
CNT_W, 8, width of err_count and wrap_count
ERR_LIMIT, 3, consecutive errors in LOCKED that drop lock (≥1)
LOCK_GOOD, 2, consecutive good steps in ACQUIRE needed to lock (≥1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  gray_in is sampled this cycle
gray_in  in  WIDTH  gray code sample
clear_err  in  1  synchronous clear of err_count and err_sticky
bin_out  out  WIDTH  binary decode of last sampled gray_in
bin_valid  out  1  one-cycle pulse, bin_out updated
step_err  out  1  one-cycle pulse, illegal step detected in LOCKED
hold  out  1  one-cycle pulse, sample equal to previous sample
locked  out  1  FSM in LOCKED
err_sticky  out  1  set on any step_err, cleared by clear_err or rst
err_count  out  CNT_W  saturating count of step_err pulses
wrap_count  out  CNT_W  count (modulo 2^CNT_W) of good all-ones→0 steps in LOCKED

Behaviour:
- Reset (rst=1 at clk edge): all outputs 0, FSM=UNLOCKED, reference and counters cleared. Reset overrides all other inputs, including mid-stream.
- Decode: bin[WIDTH-1]=g[WIDTH-1]; bin[i]=bin[i+1]^g[i]. Registered, so bin_out and bin_valid appear one cycle after the in_valid sample. bin_valid pulses for every valid sample, in every state.
- Step classification of a valid sample vs stored reference (prev gray, prev bin):
  - hold: gray_in == prev gray.
  - good: popcount(gray_in^prev)==1 and bin == prev_bin+1 mod 2^WIDTH.
  - bad: anything else, including a single-bit decrement and a multi-bit change.
- Reference is reloaded from every valid sample: good, hold or bad.
- FSM, with transitions on valid samples only (in_valid=0 leaves all state unchanged):
  - UNLOCKED: the first sample loads the reference and moves to ACQUIRE; it is not classified.
  - ACQUIRE: a good step increments good_cnt, and at good_cnt==LOCK_GOOD moves to LOCKED with good_cnt cleared. A bad step clears good_cnt. A hold changes nothing. No step_err, err_count or wrap_count activity in this state.
  - LOCKED: a good step clears bad_cnt, and if prev_bin was all-ones, increments wrap_count. A bad step pulses step_err, sets err_sticky, increments err_count (saturating at all-ones) and increments bad_cnt; at bad_cnt==ERR_LIMIT moves to UNLOCKED with bad_cnt cleared. A hold pulses hold, with no error and no change to bad_cnt.
- Output timing: step_err, hold, locked and all counters update in the same cycle as bin_out, i.e. one cycle after the sample. locked=1 exactly while the FSM is in LOCKED.
- clear_err clears err_count and err_sticky at the next edge. If step_err occurs in the same cycle, the error wins over the clear: err_count=1, err_sticky=1.

Test Plan:
1. Lock and wrap: rst for 2 cycles, then in_valid=1 with gray 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0.
   Required: bin_out follows 0..15,0 one cycle late; locked rises one cycle after the third sample (3); wrap_count=1 after the final 0; err_count=0; step_err never pulses.
2. Skip: while locked, feed 1,3,6 (2 omitted).
   Required: step_err pulses once at 6; err_count=1; err_sticky=1; locked stays 1; next sample 7 is good.
3. Hold and backward step: while locked, feed 3,3,1.
   Required: the second 3 gives hold=1 with no error; 1 (single-bit change, but bin 2→1) gives step_err=1 and err_count increments.
4. Loss of lock and relock: feed 0,5,A,0 after lock.
   Required: three step_err pulses, then locked=0; then 1,3,2 gives UNLOCKED→ACQUIRE→LOCKED, with locked=1 one cycle after 2.
5. Clear collisions and gaps: assert clear_err with err_count=5 and no error → 0 next cycle. Assert clear_err in the same cycle as a bad step → err_count=1, err_sticky=1. in_valid=0 gaps inside a legal sequence → no errors and no bin_valid pulses.
6. Reset mid-stream: assert rst while locked with err_count=2 and wrap_count=1.
   Required: next cycle all outputs 0 and locked=0. The first post-reset sample is unclassified, with no step_err even if it is non-adjacent.
